vtg_pattern_gen: RTL and testbench

Parametrised video timing generator with a built-in test-pattern source, successor to the fixed 640x480 generator. Produces hsync/vsync/data-valid for any raster given per-axis porch/sync/active parameters, with programmable sync polarity. Adds a frame-boundary-latched pattern mode, a frame counter and start-of-frame/end-of-line strobes. Sits at the head of the video pipeline, feeding the display/encoder path on px_clk.

---
 rtl/vtg_pkg.sv | 25 ++
 rtl/vtg_timing.sv | 99 +++++++++
 rtl/vtg_pattern_gen.sv | 162 ++++++++++++++++
 tb/tb_vtg_pattern_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vtg_pkg.sv
// Shared definitions for the video timing / test-pattern generator.
//   pat_mode_e : pattern selector encoding (matches mode_i)
//   BAR_RGB    : {R,G,B} on/off per colour bar, element 0 is the leftmost bar
//   bar_rgb()  : table lookup, any index past the last bar is black
package vtg_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_CHECK = 2'd3
    } pat_mode_e;

    localparam int unsigned NUM_BARS = 8;

    // Listed from element 7 down to 0: black, blue, red, magenta, green, cyan, yellow, white.
    localparam logic [NUM_BARS-1:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

    function automatic logic [2:0] bar_rgb(input logic [3:0] idx);
        bar_rgb = idx[3] ? 3'b000 : BAR_RGB[idx[2:0]];
    endfunction

endpackage

// File: rtl/vtg_timing.sv
// Raster counters and region decode.
//   px_clk, sys_rst : pixel clock, synchronous active-high reset
//   en_i            : run enable; low parks both counters at 0
//   hcnt_o, vcnt_o  : current pixel / line position
//   in_hs_o, in_vs_o: position lies inside the sync pulse region (raw, active-high)
//   hact_o, vact_o  : position lies inside the active region per axis
//   sof_o, eol_o    : current position is first active pixel of frame / last of line
//   frame_start_o   : current position is (0,0)
//   frame_cnt_o     : registered count of completed frames
module vtg_timing
    import vtg_pkg::*;
#(
    parameter int unsigned HACT = 640,
    parameter int unsigned HFP  = 16,
    parameter int unsigned HSP  = 96,
    parameter int unsigned HBP  = 48,
    parameter int unsigned VACT = 480,
    parameter int unsigned VFP  = 10,
    parameter int unsigned VSP  = 2,
    parameter int unsigned VBP  = 33,
    localparam int unsigned HTOTAL = HSP + HBP + HACT + HFP,
    localparam int unsigned VTOTAL = VSP + VBP + VACT + VFP,
    localparam int unsigned HW = $clog2(HTOTAL),
    localparam int unsigned VW = $clog2(VTOTAL)
) (
    input  logic          px_clk,
    input  logic          sys_rst,
    input  logic          en_i,
    output logic [HW-1:0] hcnt_o,
    output logic [VW-1:0] vcnt_o,
    output logic          in_hs_o,
    output logic          in_vs_o,
    output logic          hact_o,
    output logic          vact_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          frame_start_o,
    output logic [15:0]   frame_cnt_o
);

    localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HSP);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(HSP + HBP);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(HSP + HBP + HACT - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VSP);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(VSP + VBP);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(VSP + VBP + VACT - 1);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          h_last, v_last;

    assign h_last = (hcnt_q == H_LAST);
    assign v_last = (vcnt_q == V_LAST);

    always_comb begin
        hcnt_d      = hcnt_q + 1'b1;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            if (v_last && en_i) begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        // Disabled: park at frame start so re-enabling begins a fresh frame.
        if (!en_i) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end
    end

    always_ff @(posedge px_clk) begin
        if (sys_rst) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hcnt_o        = hcnt_q;
    assign vcnt_o        = vcnt_q;
    assign in_hs_o       = (hcnt_q < H_SYNC_END);
    assign in_vs_o       = (vcnt_q < V_SYNC_END);
    assign hact_o        = (hcnt_q >= H_ACT_BEG) && (hcnt_q <= H_ACT_LAST);
    assign vact_o        = (vcnt_q >= V_ACT_BEG) && (vcnt_q <= V_ACT_LAST);
    assign sof_o         = (hcnt_q == H_ACT_BEG) && (vcnt_q == V_ACT_BEG);
    assign eol_o         = (hcnt_q == H_ACT_LAST) && vact_o;
    assign frame_start_o = (hcnt_q == '0) && (vcnt_q == '0);
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: rtl/vtg_pattern_gen.sv
// Video timing generator with built-in test patterns.
//   px_clk, sys_rst          : pixel clock, synchronous active-high reset
//   en                       : run enable; low forces idle outputs and parks the raster
//   mode_i, solid_i          : pattern select and solid colour, latched at frame start
//   hsync_o, vsync_o         : syncs, asserted level HS_POL / VS_POL
//   dval_o, sof_o, eol_o     : data valid, first-pixel-of-frame, last-pixel-of-line
//   rdata_o, gdata_o, bdata_o: pixel colour, zero outside active video
//   frame_cnt_o              : completed-frame count
// All outputs are registered one cycle behind the raster counters.
module vtg_pattern_gen
    import vtg_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned HACT     = 640,
    parameter int unsigned HFP      = 16,
    parameter int unsigned HSP      = 96,
    parameter int unsigned HBP      = 48,
    parameter int unsigned VACT     = 480,
    parameter int unsigned VFP      = 10,
    parameter int unsigned VSP      = 2,
    parameter int unsigned VBP      = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic            px_clk,
    input  logic            sys_rst,
    input  logic            en,
    input  logic [1:0]      mode_i,
    input  logic [3*DW-1:0] solid_i,
    output logic            vsync_o,
    output logic            hsync_o,
    output logic            dval_o,
    output logic            sof_o,
    output logic            eol_o,
    output logic [DW-1:0]   rdata_o,
    output logic [DW-1:0]   gdata_o,
    output logic [DW-1:0]   bdata_o,
    output logic [15:0]     frame_cnt_o
);

    localparam int unsigned HTOTAL   = HSP + HBP + HACT + HFP;
    localparam int unsigned VTOTAL   = VSP + VBP + VACT + VFP;
    localparam int unsigned HW       = $clog2(HTOTAL);
    localparam int unsigned VW       = $clog2(VTOTAL);
    localparam int unsigned X0       = HSP + HBP;
    localparam int unsigned Y0       = VSP + VBP;
    localparam int unsigned BAR_W    = HACT / NUM_BARS;
    localparam int unsigned BPW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BPW-1:0] BAR_LAST = BPW'((BAR_W > 0) ? BAR_W - 1 : 0);

    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic            in_hs, in_vs, hact, vact, sof, eol, frame_start;

    pat_mode_e       mode_q;
    logic [3*DW-1:0] solid_q;
    logic [BPW-1:0]  bar_pos_q, bar_pos_d;
    logic [3:0]      bar_idx_q, bar_idx_d;
    logic [2:0]      bar_on;
    logic            chk_on;
    logic [3*DW-1:0] pix_d;

    vtg_timing #(
        .HACT (HACT),
        .HFP  (HFP),
        .HSP  (HSP),
        .HBP  (HBP),
        .VACT (VACT),
        .VFP  (VFP),
        .VSP  (VSP),
        .VBP  (VBP)
    ) u_timing (
        .px_clk        (px_clk),
        .sys_rst       (sys_rst),
        .en_i          (en),
        .hcnt_o        (hcnt),
        .vcnt_o        (vcnt),
        .in_hs_o       (in_hs),
        .in_vs_o       (in_vs),
        .hact_o        (hact),
        .vact_o        (vact),
        .sof_o         (sof),
        .eol_o         (eol),
        .frame_start_o (frame_start),
        .frame_cnt_o   (frame_cnt_o)
    );

    // Pattern settings only change at frame start so a frame is never mixed.
    always_ff @(posedge px_clk) begin
        if (sys_rst) begin
            mode_q  <= PAT_SOLID;
            solid_q <= '0;
        end else if (frame_start) begin
            mode_q  <= pat_mode_e'(mode_i);
            solid_q <= solid_i;
        end
    end

    // Bar position tracks x without a divider; idx saturates at NUM_BARS (black tail).
    always_comb begin
        bar_pos_d = bar_pos_q + 1'b1;
        bar_idx_d = bar_idx_q;
        if (bar_pos_q == BAR_LAST) begin
            bar_pos_d = '0;
            if (!bar_idx_q[3]) begin
                bar_idx_d = bar_idx_q + 1'b1;
            end
        end
        if (!en || !hact) begin
            bar_pos_d = '0;
            bar_idx_d = '0;
        end
    end

    always_ff @(posedge px_clk) begin
        if (sys_rst) begin
            bar_pos_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign bar_on = (BAR_W == 0) ? 3'b000 : bar_rgb(bar_idx_q);
    assign chk_on = (((32'(hcnt) - X0) ^ (32'(vcnt) - Y0)) & (32'd1 << CHK_LOG2)) != 32'd0;

    always_comb begin
        pix_d = '0;
        unique case (mode_q)
            PAT_SOLID: pix_d = solid_q;
            PAT_BARS:  pix_d = {{DW{bar_on[2]}}, {DW{bar_on[1]}}, {DW{bar_on[0]}}};
            PAT_GRAD:  pix_d = {3{DW'(32'(hcnt) - X0)}};
            PAT_CHECK: pix_d = {(3 * DW){chk_on}};
        endcase
        if (!(hact && vact)) begin
            pix_d = '0;
        end
    end

    always_ff @(posedge px_clk) begin
        if (sys_rst || !en) begin
            hsync_o <= ~HS_POL;
            vsync_o <= ~VS_POL;
            dval_o  <= 1'b0;
            sof_o   <= 1'b0;
            eol_o   <= 1'b0;
            rdata_o <= '0;
            gdata_o <= '0;
            bdata_o <= '0;
        end else begin
            hsync_o <= in_hs ? HS_POL : ~HS_POL;
            vsync_o <= in_vs ? VS_POL : ~VS_POL;
            dval_o  <= hact && vact;
            sof_o   <= sof;
            eol_o   <= eol;
            {rdata_o, gdata_o, bdata_o} <= pix_d;
        end
    end

endmodule

// File: tb/tb_vtg_pattern_gen.sv
// Directed bench on a small raster: 80 clocks x 47 lines, active 64x40 at (12,5),
// hsync active-high, vsync active-low, 5-bit channels, 8-pixel checker squares.
module tb_vtg_pattern_gen;

    localparam int DW    = 5;
    localparam int HT    = 80;
    localparam int VT    = 47;
    localparam int FRAME = HT * VT;

    localparam logic [3*DW-1:0] WHITE  = {5'h1f, 5'h1f, 5'h1f};
    localparam logic [3*DW-1:0] YELLOW = {5'h1f, 5'h1f, 5'h00};
    localparam logic [3*DW-1:0] CYAN   = {5'h00, 5'h1f, 5'h1f};
    localparam logic [3*DW-1:0] RED    = {5'h1f, 5'h00, 5'h00};
    localparam logic [3*DW-1:0] BLUE   = {5'h00, 5'h00, 5'h1f};
    localparam logic [3*DW-1:0] BLACK  = '0;
    localparam logic [3*DW-1:0] SOLID  = {5'h03, 5'h15, 5'h0a};

    logic            px_clk = 1'b0;
    logic            sys_rst, en;
    logic [1:0]      mode_i;
    logic [3*DW-1:0] solid_i;
    logic            vsync_o, hsync_o, dval_o, sof_o, eol_o;
    logic [DW-1:0]   rdata_o, gdata_o, bdata_o;
    logic [15:0]     frame_cnt_o;
    logic [3*DW-1:0] pix;

    int n_total = 0;
    int n_bad   = 0;
    int idx, c_dval, c_sof, c_eol, c_hs, c_vs;

    assign pix = {rdata_o, gdata_o, bdata_o};

    always #5 px_clk = ~px_clk;

    vtg_pattern_gen #(
        .DW       (DW),
        .HACT     (64),
        .HFP      (4),
        .HSP      (6),
        .HBP      (6),
        .VACT     (40),
        .VFP      (2),
        .VSP      (2),
        .VBP      (3),
        .HS_POL   (1'b1),
        .VS_POL   (1'b0),
        .CHK_LOG2 (3)
    ) dut (
        .px_clk      (px_clk),
        .sys_rst     (sys_rst),
        .en          (en),
        .mode_i      (mode_i),
        .solid_i     (solid_i),
        .vsync_o     (vsync_o),
        .hsync_o     (hsync_o),
        .dval_o      (dval_o),
        .sof_o       (sof_o),
        .eol_o       (eol_o),
        .rdata_o     (rdata_o),
        .gdata_o     (gdata_o),
        .bdata_o     (bdata_o),
        .frame_cnt_o (frame_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t idx=%0d)", tag, got, exp, $time, idx);
        end
    endtask

    // After tick k (k from 0) the outputs describe raster position k.
    task automatic tick();
        @(posedge px_clk);
        #1;
        idx++;
        if (dval_o)  c_dval++;
        if (sof_o)   c_sof++;
        if (eol_o)   c_eol++;
        if (hsync_o) c_hs++;
        if (!vsync_o) c_vs++;
    endtask

    task automatic step_to(input int target);
        while (idx < target) tick();
    endtask

    task automatic restart_count();
        idx    = -1;
        c_dval = 0;
        c_sof  = 0;
        c_eol  = 0;
        c_hs   = 0;
        c_vs   = 0;
    endtask

    function automatic int at(input int h, input int v);
        return v * HT + h;
    endfunction

    task automatic check_idle(input string tag);
        check_eq({tag, "_hs"}, 32'(hsync_o), 32'd0);
        check_eq({tag, "_vs"}, 32'(vsync_o), 32'd1);
        check_eq({tag, "_dval"}, 32'(dval_o), 32'd0);
        check_eq({tag, "_strobes"}, {30'd0, sof_o, eol_o}, 32'd0);
        check_eq({tag, "_pix"}, 32'(pix), 32'd0);
    endtask

    initial begin
        sys_rst = 1'b1;
        en      = 1'b0;
        mode_i  = 2'd1;
        solid_i = '0;
        restart_count();
        repeat (2) tick();
        check_idle("rst");
        check_eq("rst_fcnt", 32'(frame_cnt_o), 32'd0);

        sys_rst = 1'b0;
        repeat (4) tick();
        check_idle("en_low");

        // Frame 0: colour bars.
        en = 1'b1;
        restart_count();
        step_to(at(0, 0));   check_eq("hs_h0", 32'(hsync_o), 32'd1);
                             check_eq("vs_v0", 32'(vsync_o), 32'd0);
        step_to(at(5, 0));   check_eq("hs_h5", 32'(hsync_o), 32'd1);
        step_to(at(6, 0));   check_eq("hs_h6", 32'(hsync_o), 32'd0);
        step_to(at(79, 1));  check_eq("vs_v1", 32'(vsync_o), 32'd0);
        step_to(at(0, 2));   check_eq("vs_v2", 32'(vsync_o), 32'd1);
        step_to(at(11, 5));  check_eq("dval_pre", 32'(dval_o), 32'd0);
                             check_eq("sof_pre", 32'(sof_o), 32'd0);
        step_to(at(12, 5));  check_eq("sof", 32'(sof_o), 32'd1);
                             check_eq("dval_first", 32'(dval_o), 32'd1);
                             check_eq("bar_x0", 32'(pix), 32'(WHITE));
        step_to(at(13, 5));  check_eq("sof_once", 32'(sof_o), 32'd0);
        step_to(at(19, 5));  check_eq("bar_x7", 32'(pix), 32'(WHITE));
        step_to(at(20, 5));  check_eq("bar_x8", 32'(pix), 32'(YELLOW));
        step_to(at(28, 5));  check_eq("bar_x16", 32'(pix), 32'(CYAN));
        step_to(at(52, 5));  check_eq("bar_x40", 32'(pix), 32'(RED));
        step_to(at(60, 5));  check_eq("bar_x48", 32'(pix), 32'(BLUE));
        step_to(at(74, 5));  check_eq("eol_pre", 32'(eol_o), 32'd0);
        step_to(at(75, 5));  check_eq("eol", 32'(eol_o), 32'd1);
                             check_eq("bar_x63", 32'(pix), 32'(BLACK));
        step_to(at(76, 5));  check_eq("dval_fp", 32'(dval_o), 32'd0);
        step_to(at(0, 20));  mode_i = 2'd2;
        step_to(at(20, 30)); check_eq("mode_hold", 32'(pix), 32'(YELLOW));
        step_to(at(75, 44)); check_eq("eol_last", 32'(eol_o), 32'd1);
        step_to(at(12, 45)); check_eq("dval_vfp", 32'(dval_o), 32'd0);
        step_to(FRAME - 2);  check_eq("fcnt_pre", 32'(frame_cnt_o), 32'd0);
        step_to(FRAME - 1);  check_eq("fcnt_1", 32'(frame_cnt_o), 32'd1);
        check_eq("cnt_dval", c_dval, 32'd2560);
        check_eq("cnt_sof", c_sof, 32'd1);
        check_eq("cnt_eol", c_eol, 32'd40);
        check_eq("cnt_hs", c_hs, 32'd282);
        check_eq("cnt_vs", c_vs, 32'd160);

        // Frame 1: gradient, x mod 32.
        step_to(FRAME + at(43, 5)); check_eq("grad_x31", 32'(pix), 32'(WHITE));
        step_to(FRAME + at(52, 5)); check_eq("grad_x40", 32'(pix), 32'({5'h08, 5'h08, 5'h08}));
        mode_i = 2'd3;
        step_to(FRAME + at(15, 37)); check_eq("grad_x3", 32'(pix), 32'({5'h03, 5'h03, 5'h03}));
        step_to(2 * FRAME - 1);      check_eq("fcnt_2", 32'(frame_cnt_o), 32'd2);

        // Frame 2: checker with 8-pixel squares.
        step_to(2 * FRAME + at(12, 5));  check_eq("chk_x0y0", 32'(pix), 32'd0);
        step_to(2 * FRAME + at(19, 5));  check_eq("chk_x7y0", 32'(pix), 32'd0);
        step_to(2 * FRAME + at(20, 5));  check_eq("chk_x8y0", 32'(pix), 32'(WHITE));
        step_to(2 * FRAME + at(12, 13)); check_eq("chk_x0y8", 32'(pix), 32'(WHITE));
        step_to(2 * FRAME + at(20, 13)); check_eq("chk_x8y8", 32'(pix), 32'd0);

        // Abort mid-line with en.
        step_to(2 * FRAME + at(30, 20));
        en      = 1'b0;
        mode_i  = 2'd0;
        solid_i = SOLID;
        tick();
        check_idle("abort");
        check_eq("abort_fcnt", 32'(frame_cnt_o), 32'd2);
        repeat (5) tick();
        check_idle("abort_hold");

        // Restart: fresh frame in solid mode.
        en = 1'b1;
        restart_count();
        step_to(at(0, 0));   check_eq("re_hs_h0", 32'(hsync_o), 32'd1);
        step_to(at(12, 5));  check_eq("re_sof", 32'(sof_o), 32'd1);
                             check_eq("re_solid", 32'(pix), 32'(SOLID));
        step_to(at(75, 5));  check_eq("re_eol", 32'(eol_o), 32'd1);
                             check_eq("re_fcnt", 32'(frame_cnt_o), 32'd2);

        // Synchronous reset mid-frame.
        step_to(at(40, 12));
        sys_rst = 1'b1;
        mode_i  = 2'd1;
        tick();
        check_idle("mid_rst");
        check_eq("mid_rst_fcnt", 32'(frame_cnt_o), 32'd0);
        sys_rst = 1'b0;
        restart_count();
        step_to(at(0, 0));   check_eq("rr_hs_h0", 32'(hsync_o), 32'd1);
                             check_eq("rr_vs_v0", 32'(vsync_o), 32'd0);
        step_to(at(12, 5));  check_eq("rr_sof", 32'(sof_o), 32'd1);
                             check_eq("rr_bar_x0", 32'(pix), 32'(WHITE));
        step_to(at(20, 5));  check_eq("rr_bar_x8", 32'(pix), 32'(YELLOW));
        step_to(FRAME - 1);  check_eq("rr_fcnt", 32'(frame_cnt_o), 32'd1);
        check_eq("rr_cnt_sof", c_sof, 32'd1);
        check_eq("rr_cnt_eol", c_eol, 32'd40);
        check_eq("rr_cnt_dval", c_dval, 32'd2560);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
